// File: rtl/line_fetch_if.sv
// rtl/line_fetch_if.sv - fetch command, data-array and memory-bus signals of the line fetch engine
interface line_fetch_if #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int list_depth = 4,
    parameter int list_width = 32
);
    localparam int TAG_W   = $clog2(list_depth);
    localparam int MADDR_W = $clog2(list_depth) + $clog2(list_width);

    logic                  fetch_req;
    logic [1:0]            fetch_cmd;
    logic [TAG_W-1:0]      fetch_tag;
    logic [addr_width-1:0] fetch_addr;
    logic                  fetch_gnt;
    logic                  fetch_done;
    logic                  busy;

    logic [MADDR_W-1:0]    mem_waddr;
    logic                  mem_wen;
    logic [data_width-1:0] mem_wdata;

    logic [MADDR_W-1:0]    wb_mem_raddr;
    logic                  wb_mem_ren;
    logic                  wb_mem_rready;
    logic [data_width-1:0] wb_mem_rdata;

    logic                  bus_req;
    logic                  bus_we;
    logic [addr_width-1:0] bus_addr;
    logic [data_width-1:0] bus_wdata;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [data_width-1:0] bus_rdata;

    // master: the fetch engine itself; slave: read controller, data array and bus around it
    modport master (
        input  fetch_req, fetch_cmd, fetch_tag, fetch_addr,
        output fetch_gnt, fetch_done, busy,
        output mem_waddr, mem_wen, mem_wdata,
        output wb_mem_raddr, wb_mem_ren,
        input  wb_mem_rready, wb_mem_rdata,
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        output fetch_req, fetch_cmd, fetch_tag, fetch_addr,
        input  fetch_gnt, fetch_done, busy,
        input  mem_waddr, mem_wen, mem_wdata,
        input  wb_mem_raddr, wb_mem_ren,
        output wb_mem_rready, wb_mem_rdata,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/line_fetch_ctrl.sv
// rtl/line_fetch_ctrl.sv - cache line refill / dirty-line writeback engine
module line_fetch_ctrl #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int list_depth = 4,
    parameter int list_width = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    line_fetch_if.master   fif
);
    localparam int TW  = $clog2(list_depth);
    localparam int IW  = $clog2(list_width);
    localparam int CW  = IW + 1;
    localparam int BSH = $clog2(data_width / 8);
    localparam int OFF = BSH + IW;

    localparam logic [CW-1:0]         FULL      = CW'(list_width);
    localparam logic [CW-1:0]         LAST      = CW'(list_width - 1);
    localparam logic [addr_width-1:0] BASE_MASK = {{(addr_width - OFF){1'b1}}, {OFF{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WB_RD = 3'd2,
        S_WB_WR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tag_q, tag_d;
    logic [addr_width-1:0] base_q, base_d;
    logic [CW-1:0]         ic_q, ic_d;
    logic [CW-1:0]         rc_q, rc_d;
    logic [CW-1:0]         wc_q, wc_d;
    logic [data_width-1:0] wdata_q, wdata_d;
    logic                  gnt;

    function automatic logic [addr_width-1:0] beat_addr(input logic [addr_width-1:0] base,
                                                       input logic [CW-1:0] k);
        return base + ({{(addr_width - CW){1'b0}}, k} << BSH);
    endfunction

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        base_d  = base_q;
        ic_d    = ic_q;
        rc_d    = rc_q;
        wc_d    = wc_q;
        wdata_d = wdata_q;
        gnt     = 1'b0;

        fif.fetch_gnt    = 1'b0;
        fif.fetch_done   = 1'b0;
        fif.busy         = 1'b0;
        fif.mem_waddr    = '0;
        fif.mem_wen      = 1'b0;
        fif.mem_wdata    = '0;
        fif.wb_mem_raddr = '0;
        fif.wb_mem_ren   = 1'b0;
        fif.bus_req      = 1'b0;
        fif.bus_we       = 1'b0;
        fif.bus_addr     = '0;
        fif.bus_wdata    = '0;

        case (state_q)
            S_IDLE: begin
                // gating with rst_n keeps every output low while reset is held
                if (fif.fetch_req && rst_n) begin
                    gnt    = 1'b1;
                    tag_d  = fif.fetch_tag;
                    base_d = fif.fetch_addr & BASE_MASK;
                    ic_d   = '0;
                    rc_d   = '0;
                    wc_d   = '0;
                    case (fif.fetch_cmd)
                        2'b01:   state_d = S_FILL;
                        2'b10:   state_d = S_WB_RD;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_FILL: begin
                if (ic_q < FULL) begin
                    fif.bus_req  = 1'b1;
                    fif.bus_addr = beat_addr(base_q, ic_q);
                    if (fif.bus_gnt) ic_d = ic_q + 1'b1;
                end
                // responses are in order, so rc alone names the target word
                if (fif.bus_rvalid && (rc_q < FULL)) begin
                    fif.mem_wen   = 1'b1;
                    fif.mem_waddr = {tag_q, rc_q[IW-1:0]};
                    fif.mem_wdata = fif.bus_rdata;
                    rc_d          = rc_q + 1'b1;
                    if (rc_q == LAST) state_d = S_DONE;
                end
            end
            S_WB_RD: begin
                fif.wb_mem_ren   = 1'b1;
                fif.wb_mem_raddr = {tag_q, wc_q[IW-1:0]};
                if (fif.wb_mem_rready) begin
                    wdata_d = fif.wb_mem_rdata;
                    state_d = S_WB_WR;
                end
            end
            S_WB_WR: begin
                fif.bus_req   = 1'b1;
                fif.bus_we    = 1'b1;
                fif.bus_addr  = beat_addr(base_q, wc_q);
                fif.bus_wdata = wdata_q;
                if (fif.bus_gnt) begin
                    if (wc_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        wc_d    = wc_q + 1'b1;
                        state_d = S_WB_RD;
                    end
                end
            end
            S_DONE: begin
                fif.fetch_done = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        fif.fetch_gnt = gnt;
        fif.busy      = (state_q != S_IDLE) || gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            base_q  <= '0;
            ic_q    <= '0;
            rc_q    <= '0;
            wc_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            base_q  <= base_d;
            ic_q    <= ic_d;
            rc_q    <= rc_d;
            wc_q    <= wc_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: doc/line_fetch_ctrl.md
Name: line_fetch_ctrl

Overview:
- Refill/writeback engine directly downstream of the cache read controller's fetch interface.
- Accepts one fetch command at a time: line fill or dirty-line writeback.
- Moves one cache line, word by word, between the external memory bus and the cache data array, then pulses fetch_done.
- Owns the data-array write port and a dedicated data-array read port used for writeback.

Parameters:
- addr_width, 32, byte address width of fetch/bus addresses
- data_width, 32, word width; multiple of 8
- list_depth, 4, number of cache lines (slots); power of 2
- list_width, 32, words per line; power of 2, >=2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- fetch_req  in  1  fetch command request from read controller
- fetch_cmd  in  2  2'b01 FILL, 2'b10 WRITEBACK, 2'b00/2'b11 NOP
- fetch_tag  in  $clog2(list_depth)  target line slot
- fetch_addr  in  addr_width  any byte address inside the target line
- fetch_gnt  out  1  one-cycle accept pulse
- fetch_done  out  1  one-cycle completion pulse
- busy  out  1  high from accept until fetch_done inclusive
- mem_waddr  out  $clog2(list_depth)+$clog2(list_width)  {tag, word index}
- mem_wen  out  1  data-array write strobe
- mem_wdata  out  data_width  write data
- wb_mem_raddr  out  $clog2(list_depth)+$clog2(list_width)  {tag, word index}
- wb_mem_ren  out  1  data-array read request
- wb_mem_rready  in  1  wb_mem_rdata valid for the outstanding read
- wb_mem_rdata  in  data_width  read data
- bus_req  out  1  bus transaction request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  addr_width  word-aligned byte address
- bus_wdata  out  data_width  write data
- bus_gnt  in  1  beat accepted when bus_req && bus_gnt
- bus_rvalid  in  1  read response valid; responses return in order
- bus_rdata  in  data_width  read response data

Behaviour:
- Reset: asynchronous, active-low on rst_n, one clock clk. All outputs 0, state IDLE, all counters 0. Reset mid-operation aborts the transfer; no fetch_done is produced.
- Address decomposition:
  - OFF = $clog2(data_width/8) + $clog2(list_width).
  - Line base = fetch_addr with its low OFF bits cleared.
  - Beat k address = base + k*(data_width/8), modulo 2^addr_width.
- States: IDLE, FILL, WB_RD, WB_WR, DONE.
- IDLE:
  - fetch_req=1: assert fetch_gnt for that cycle, latch cmd/tag/base, reset counters.
  - Next state: FILL for 01, WB_RD for 10, DONE for 00/11.
  - fetch_gnt is only ever asserted in IDLE.
- FILL:
  - Issue counter ic and response counter rc, both 0..list_width.
  - bus_req=1 and bus_we=0 while ic<list_width; bus_addr = beat ic; ic increments on bus_gnt.
  - Multiple reads may be outstanding.
  - Each bus_rvalid produces mem_wen=1, mem_waddr={tag,rc}, mem_wdata=bus_rdata in the same cycle (combinational pass-through), then rc increments.
  - A bus_rvalid coincident with a bus_gnt is handled in the same cycle.
  - When the rvalid with rc=list_width-1 is written, go to DONE.
  - bus_rvalid outside FILL is ignored.
- WB_RD:
  - Hold wb_mem_ren=1, wb_mem_raddr={tag,wc} until wb_mem_rready.
  - On rready: capture wb_mem_rdata into a data register, go to WB_WR.
- WB_WR:
  - bus_req=1, bus_we=1, bus_addr = beat wc, bus_wdata = captured data; hold until bus_gnt.
  - On gnt with wc=list_width-1: go to DONE. Otherwise wc+1 and go to WB_RD.
- DONE: fetch_done=1 for one cycle, then IDLE. A new fetch_req is granted no earlier than the cycle after fetch_done.
- All strobe outputs are 0 outside their state. bus_addr, bus_wdata and mem_* are 0 when their strobe is low.
- Latency:
  - FILL with bus_gnt always high and rvalid 1 cycle after gnt: fetch_done exactly list_width+2 cycles after fetch_gnt.
  - NOP: fetch_done 1 cycle after fetch_gnt.
- Counters are $clog2(list_width)+1 bits wide. Word index into mem_*addr uses the low $clog2(list_width) bits.

Test Plan:
- FILL, tag=2, fetch_addr=0x0000_1234, gnt=1, rvalid 1 cycle after gnt (default params) -> bus_addr 0x1200..0x127C step 4; 32 mem writes to addr 64..95 carrying the matching bus_rdata; fetch_done 34 cycles after fetch_gnt; busy high throughout.
- FILL with bus_gnt toggling 1/0 and rvalid latency 3 -> exactly 32 bus beats, no duplicate or missing mem_waddr, done after last response only.
- WRITEBACK, tag=1, addr=0xFFFF_FF80, wb_mem_rready 2 cycles after ren, gnt after 1 cycle -> bus writes to 0xFFFF_FF80..0xFFFF_FFFC carrying rdata of mem addr 32..63 in order; no mem_wen.
- fetch_cmd=2'b00 and 2'b11 -> fetch_gnt then fetch_done next cycle; no bus/mem activity.
- fetch_req held high back-to-back -> second fetch_gnt no earlier than the cycle after first fetch_done.
- rst_n low at FILL beat 10 -> outputs 0 immediately; after release, a new FILL starts from beat 0; no stray fetch_done.
